// File: rtl/bias_ctrl.sv
// -----------------------------------------------------------------------------
// bias_ctrl
//
// Sequencer for the per-column bias adders on the systolic array output.
// A tile begins with an accepted start. Unless stored biases are reused, one
// bias word per column is loaded over a ready/valid stream. The controller then
// strobes each column's bias_valid on that column's first output row. On that
// row the adder takes the bypass path, and on later rows it uses its stored
// bias. Rows are counted per column. Tile completion is pulsed on done_o, and
// protocol violations raise a sticky err_o.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   start_i        start a tile (only honoured in IDLE)
//   reuse_i        with start_i: skip LOAD if biases are already loaded
//   num_rows_i     rows per column for the tile, latched on accepted start
//   bias_wvalid_i  bias stream valid
//   bias_wready_o  bias stream ready (high only in LOAD)
//   bias_wdata_i   bias word; k-th accepted word goes to column k
//   col_valid_i    per-column data valid at the bias adder input
//   bias_o         packed biases, column c at [c*BIAS_W +: BIAS_W]
//   bias_valid_o   per-column bias load strobe (first row of each column)
//   busy_o         controller is not idle
//   done_o         one-cycle tile-complete pulse
//   err_o          sticky protocol error, cleared on accepted start
// -----------------------------------------------------------------------------
module bias_ctrl #(
  parameter int N_COLS = 8,
  parameter int BIAS_W = 32,
  parameter int ROWS_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     reuse_i,
  input  logic [ROWS_W-1:0]        num_rows_i,
  input  logic                     bias_wvalid_i,
  output logic                     bias_wready_o,
  input  logic [BIAS_W-1:0]        bias_wdata_i,
  input  logic [N_COLS-1:0]        col_valid_i,
  output logic [N_COLS*BIAS_W-1:0] bias_o,
  output logic [N_COLS-1:0]        bias_valid_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int PTR_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  // Stored tile configuration and bias bank
  logic [BIAS_W-1:0] r_bias [N_COLS];
  logic              r_loaded;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [ROWS_W-1:0] r_num_rows;
  logic [ROWS_W-1:0] r_row_cnt [N_COLS];
  logic              r_err;

  // Decoded control
  logic              w_run;
  logic              w_start_ok;
  logic              w_start_bad;
  logic              w_load_wr;
  logic [N_COLS-1:0] w_col_first;
  logic [N_COLS-1:0] w_col_inc;
  logic [N_COLS-1:0] w_col_over;
  logic [N_COLS-1:0] w_col_full;
  logic              w_all_full;
  logic              w_err_set;
  logic [N_COLS*BIAS_W-1:0] w_bias_flat;

  assign w_run = (r_state == S_RUN);

  // ---------------------------------------------------------------------------
  // Per-column row tracking.
  // A column is "full" when its counter already equals num_rows, or when it
  // reaches num_rows this cycle. Counting the in-flight increment lets the FSM
  // leave RUN right after the last row, so done_o lands exactly one cycle
  // after the final valid.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    w_col_first = '0;
    w_col_inc   = '0;
    w_col_over  = '0;
    w_col_full  = '0;
    for (int c = 0; c < N_COLS; c++) begin
      w_col_first[c] = w_run && col_valid_i[c] && (r_row_cnt[c] == '0);
      w_col_inc[c]   = w_run && col_valid_i[c] && (r_row_cnt[c] != r_num_rows);
      w_col_over[c]  = w_run && col_valid_i[c] && (r_row_cnt[c] == r_num_rows);
      w_col_full[c]  = (r_row_cnt[c] == r_num_rows) ||
                       (w_col_inc[c] && ((r_row_cnt[c] + ROWS_W'(1)) == r_num_rows));
    end
  end

  assign w_all_full = &w_col_full;

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_load_wr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (num_rows_i != '0) begin
            w_start_ok  = 1'b1;
            // Reuse is only meaningful once a full bias set has been loaded.
            w_state_nxt = (reuse_i && r_loaded) ? S_RUN : S_LOAD;
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (bias_wvalid_i) begin
          w_load_wr = 1'b1;
          if (r_wr_ptr == LAST_PTR) begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (w_all_full) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Any column activity outside RUN is a protocol error. This includes the
  // cycle of the final LOAD write, where the state is still LOAD.
  assign w_err_set = w_start_bad || (!w_run && (|col_valid_i)) || (|w_col_over);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state is written with non-blocking assignments, so every
    // register samples the pre-edge values regardless of block ordering.
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Bias bank and write pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the bias bank is deliberately reset. After reset bias_o must read
      // zero, and a reuse request must not expose stale biases.
      for (int c = 0; c < N_COLS; c++) begin
        r_bias[c] <= '0;
      end
      r_loaded <= 1'b0;
      r_wr_ptr <= '0;
    end else if (w_load_wr) begin
      r_bias[r_wr_ptr] <= bias_wdata_i;
      if (r_wr_ptr == LAST_PTR) begin
        r_wr_ptr <= '0;
        r_loaded <= 1'b1;
      end else begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Row count configuration and per-column row counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_num_rows <= '0;
      for (int c = 0; c < N_COLS; c++) begin
        r_row_cnt[c] <= '0;
      end
    end else if (w_start_ok) begin
      r_num_rows <= num_rows_i;
      for (int c = 0; c < N_COLS; c++) begin
        r_row_cnt[c] <= '0;
      end
    end else begin
      // Counters saturate at num_rows; an overrun only raises err_o.
      for (int c = 0; c < N_COLS; c++) begin
        if (w_col_inc[c]) begin
          r_row_cnt[c] <= r_row_cnt[c] + ROWS_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error. A violation in the same cycle as an accepted start is still
  // reported, so set takes priority over clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_bias_flat = '0;
    for (int c = 0; c < N_COLS; c++) begin
      w_bias_flat[c*BIAS_W +: BIAS_W] = r_bias[c];
    end
  end

  assign bias_o        = w_bias_flat;
  assign bias_valid_o  = w_col_first;
  assign bias_wready_o = (r_state == S_LOAD);
  assign busy_o        = (r_state != S_IDLE);
  // DONE is a registered state, so done_o follows the final valid by one cycle.
  assign done_o        = (r_state == S_DONE);
  assign err_o         = r_err;

endmodule

// File: tb/tb_bias_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bias_ctrl
//
// Randomized bench for bias_ctrl. The stimulus tasks drive tiles and keep a
// tile-level reference model: the stored biases, the loaded flag, per-column
// row counts, and the expected error flag. Expected bias_valid/done events are
// queued with their cycle stamps. A negedge monitor pops the queue and compares
// against whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_bias_ctrl;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int RW = 16;

  typedef logic [N*W-1:0] cv_t;

  typedef struct {
    int          cyc;
    int          kind;  // 0: bias_valid on col, 1: done
    int          col;
    logic [W-1:0] val;
  } ev_t;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic            reuse_i = 1'b0;
  logic [RW-1:0]   num_rows_i = '0;
  logic            bias_wvalid_i = 1'b0;
  logic            bias_wready_o;
  logic [W-1:0]    bias_wdata_i = '0;
  logic [N-1:0]    col_valid_i = '0;
  logic [N*W-1:0]  bias_o;
  logic [N-1:0]    bias_valid_o;
  logic            busy_o;
  logic            done_o;
  logic            err_o;

  bias_ctrl #(.N_COLS(N), .BIAS_W(W), .ROWS_W(RW)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .reuse_i      (reuse_i),
    .num_rows_i   (num_rows_i),
    .bias_wvalid_i(bias_wvalid_i),
    .bias_wready_o(bias_wready_o),
    .bias_wdata_i (bias_wdata_i),
    .col_valid_i  (col_valid_i),
    .bias_o       (bias_o),
    .bias_valid_o (bias_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [W-1:0] m_bias [N];
  bit           m_loaded;
  int           m_cnt [N];
  bit           exp_err;
  ev_t          q [$];

  task automatic check(input string name, input cv_t got, input cv_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic cv_t model_flat();
    cv_t f;
    f = '0;
    for (int c = 0; c < N; c++) f[c*W +: W] = m_bias[c];
    return f;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic [N-1:0] mon_mask;
  logic [W-1:0] mon_val [N];
  bit           mon_done;
  ev_t          mon_e;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      mon_mask = '0;
      mon_done = 1'b0;
      for (int c = 0; c < N; c++) mon_val[c] = '0;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        mon_e = q.pop_front();
        if (mon_e.kind == 0) begin
          mon_mask[mon_e.col] = 1'b1;
          mon_val[mon_e.col]  = mon_e.val;
        end else begin
          mon_done = 1'b1;
        end
      end
      if (bias_valid_o != '0 || mon_mask != '0) begin
        check("bias_valid_o", cv_t'(bias_valid_o), cv_t'(mon_mask));
        for (int c = 0; c < N; c++) begin
          if (mon_mask[c] && bias_valid_o[c])
            check($sformatf("bias_o_col%0d", c), cv_t'(bias_o[c*W +: W]), cv_t'(mon_val[c]));
        end
      end
      if (done_o || mon_done) check("done_o", cv_t'(done_o), cv_t'(mon_done));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks
  // ---------------------------------------------------------------------------
  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   cv_t'(busy_o),        '0);
    check({tag, "_done"},   cv_t'(done_o),        '0);
    check({tag, "_err"},    cv_t'(err_o),         '0);
    check({tag, "_wready"}, cv_t'(bias_wready_o), '0);
    check({tag, "_bvalid"}, cv_t'(bias_valid_o),  '0);
    check({tag, "_bias"},   bias_o,               '0);
  endtask

  task automatic do_start(input int nrows, input bit reuse, output bit load);
    @(posedge clk_i); #1;
    start_i    = 1'b1;
    reuse_i    = reuse;
    num_rows_i = RW'(nrows);
    if (nrows != 0) begin
      load    = !(reuse && m_loaded);
      exp_err = 1'b0;
      for (int c = 0; c < N; c++) m_cnt[c] = 0;
    end else begin
      load    = 1'b0;
      exp_err = 1'b1;
    end
    @(posedge clk_i); #1;
    start_i    = 1'b0;
    reuse_i    = 1'b0;
    num_rows_i = RW'($urandom);  // must not matter once latched
    @(negedge clk_i);
    check("start_busy",   cv_t'(busy_o),        cv_t'(nrows != 0));
    check("start_wready", cv_t'(bias_wready_o), cv_t'(nrows != 0 && load));
    check("start_err",    cv_t'(err_o),         cv_t'(exp_err));
    check("start_bias",   bias_o,               model_flat());
  endtask

  task automatic do_load(input bit fixed, input bit toggle, input bit inject);
    int ptr;
    int i;
    ptr = 0;
    i   = 0;
    while (ptr < N) begin
      @(posedge clk_i); #1;
      bias_wvalid_i = toggle ? (i % 2 == 0) : (($urandom % 2 == 1) || i > 40);
      bias_wdata_i  = fixed ? W'(10 + ptr) : W'($urandom);
      col_valid_i   = '0;
      if (inject && i == 1) begin
        col_valid_i = 8'h10;
        exp_err     = 1'b1;
      end
      if (bias_wvalid_i) begin
        m_bias[ptr] = bias_wdata_i;
        ptr++;
      end
      @(negedge clk_i);
      check("wready_in_load", cv_t'(bias_wready_o), cv_t'(1'b1));
      i++;
    end
    @(posedge clk_i); #1;
    bias_wvalid_i = 1'b0;
    bias_wdata_i  = W'($urandom);
    col_valid_i   = '0;
    m_loaded      = 1'b1;
    @(negedge clk_i);
    check("wready_after_load", cv_t'(bias_wready_o), '0);
    check("busy_after_load",   cv_t'(busy_o),        cv_t'(1'b1));
    check("bias_after_load",   bias_o,               model_flat());
    check("err_after_load",    cv_t'(err_o),         cv_t'(exp_err));
  endtask

  // mode 0: column c valid for nrows consecutive cycles starting at cycle c.
  // mode 1: random valids per column. xcol/xt add one overrun valid.
  task automatic run_tile(input int nrows, input int mode, input int xcol, input int xt);
    int t;
    bit fin;
    bit v;
    logic [N-1:0] cv;
    t   = 0;
    fin = 1'b0;
    while (!fin) begin
      @(posedge clk_i); #1;
      cv = '0;
      for (int c = 0; c < N; c++) begin
        if (m_cnt[c] < nrows) begin
          v = (mode == 0) ? (t >= c) : ((t > 60) || ($urandom % 2 == 1));
          if (v) begin
            cv[c] = 1'b1;
            if (m_cnt[c] == 0) q.push_back('{cyc: cyc, kind: 0, col: c, val: m_bias[c]});
            m_cnt[c]++;
          end
        end
      end
      if (xcol >= 0 && t == xt) begin
        cv[xcol] = 1'b1;
        exp_err  = 1'b1;
      end
      col_valid_i = cv;
      fin = 1'b1;
      for (int c = 0; c < N; c++) if (m_cnt[c] != nrows) fin = 1'b0;
      if (fin) q.push_back('{cyc: cyc + 1, kind: 1, col: 0, val: '0});
      t++;
    end
    @(posedge clk_i); #1;
    col_valid_i = '0;
    @(negedge clk_i);
    check("busy_in_done", cv_t'(busy_o), cv_t'(1'b1));
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("busy_after_done", cv_t'(busy_o), '0);
    check("err_tile_end",    cv_t'(err_o),  cv_t'(exp_err));
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit load;
    int n;
    for (int c = 0; c < N; c++) begin
      m_bias[c] = '0;
      m_cnt[c]  = 0;
    end
    m_loaded = 1'b0;
    exp_err  = 1'b0;

    repeat (3) @(negedge clk_i);
    check_quiet("reset");
    rst_ni = 1'b1;

    // Load 10..17 with toggling valid, three skewed rows per column
    do_start(3, 1'b0, load);
    do_load(1'b1, 1'b1, 1'b0);
    run_tile(3, 0, -1, 0);

    // Reuse: no LOAD, same biases, two random rows per column
    do_start(2, 1'b1, load);
    if (load) do_load(1'b0, 1'b0, 1'b0);
    run_tile(2, 1, -1, 0);

    // Fresh random load with a column valid injected during LOAD
    n = 1 + int'($urandom % 4);
    do_start(n, 1'b0, load);
    do_load(1'b0, 1'b0, 1'b1);
    run_tile(n, 1, -1, 0);

    // Reuse with a fourth valid on column 2 after it has finished
    do_start(3, 1'b1, load);
    if (load) do_load(1'b0, 1'b0, 1'b0);
    run_tile(3, 0, 2, 5);

    // Zero-row start is ignored and flags an error; a good start clears it
    do_start(0, 1'b0, load);
    n = 1 + int'($urandom % 4);
    do_start(n, 1'b1, load);
    if (load) do_load(1'b0, 1'b0, 1'b0);
    run_tile(n, 1, -1, 0);

    // Reset after one row of a reused tile
    do_start(3, 1'b1, load);
    if (load) do_load(1'b0, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    col_valid_i = '1;
    for (int c = 0; c < N; c++) begin
      q.push_back('{cyc: cyc, kind: 0, col: c, val: m_bias[c]});
      m_cnt[c] = 1;
    end
    @(posedge clk_i); #1;
    col_valid_i = '0;
    rst_ni      = 1'b0;
    for (int c = 0; c < N; c++) begin
      m_bias[c] = '0;
      m_cnt[c]  = 0;
    end
    m_loaded = 1'b0;
    exp_err  = 1'b0;
    #2;
    check_quiet("midreset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Reuse after reset must fall back to LOAD with zeroed biases
    do_start(2, 1'b1, load);
    if (load) do_load(1'b0, 1'b0, 1'b0);
    run_tile(2, 1, -1, 0);

    // A few random tiles
    for (int k = 0; k < 4; k++) begin
      n = 1 + int'($urandom % 4);
      do_start(n, ($urandom % 2 == 1), load);
      if (load) do_load(1'b0, ($urandom % 2 == 1), 1'b0);
      run_tile(n, 1, -1, 0);
    end

    repeat (3) @(negedge clk_i);
    check("scoreboard_empty", cv_t'(q.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bias_ctrl.md
Name: bias_ctrl

Overview:
- Sequencer for the bank of per-column bias adders on the systolic array output.
- Loads one bias word per column over a ready/valid stream, then drives each column's bias and bias-valid.
- bias_valid is pulsed exactly on each column's first output row, so the adder takes the bypass path; later rows use the adder's stored bias.
- Counts rows per column, reports tile completion and flags protocol errors.

Parameters:
N_COLS, 8, number of array columns / bias adders
BIAS_W, 32, bias word width (signed)
ROWS_W, 16, width of row count

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  start tile; sampled only in IDLE
reuse_i  in  1  with start_i: skip LOAD, reuse stored biases
num_rows_i  in  ROWS_W  rows per column for this tile; latched on accepted start
bias_wvalid_i  in  1  bias stream valid
bias_wready_o  out  1  bias stream ready
bias_wdata_i  in  BIAS_W  bias word; k-th accepted word goes to column k
col_valid_i  in  N_COLS  per-column data_valid, as seen at the bias adder input
bias_o  out  N_COLS*BIAS_W  column c in bits [c*BIAS_W +: BIAS_W]
bias_valid_o  out  N_COLS  per-column bias load strobe
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle tile-complete pulse
err_o  out  1  sticky protocol error; cleared on accepted start

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All bias registers 0; loaded flag 0; write pointer 0; row counters 0.
  - done_o=0, err_o=0, busy_o=0, bias_wready_o=0, bias_valid_o=0.
  - Reset mid-tile discards everything, including the loaded flag.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: start accepted when start_i=1 and num_rows_i!=0.
  - Latch num_rows_i; clear row counters; clear err_o.
  - Next state is RUN if reuse_i=1 and loaded=1, otherwise LOAD.
  - start_i with num_rows_i==0: ignored, state stays IDLE, err_o set.
  - reuse_i with loaded=0 behaves as reuse_i=0.
- LOAD:
  - bias_wready_o=1 (combinational from state); low in all other states.
  - Handshake: a word is accepted on each cycle where bias_wvalid_i=1 in LOAD.
  - Each accepted word writes bias[wr_ptr], then wr_ptr increments.
  - On acceptance with wr_ptr==N_COLS-1: wr_ptr returns to 0, loaded set to 1, next state RUN.
  - Stalls on bias_wvalid_i have no limit.
- RUN:
  - bias_o is driven directly from the bias registers in all states; the registers are stable outside LOAD.
  - bias_valid_o[c] = RUN and col_valid_i[c] and row_cnt[c]==0 (combinational; same cycle as that column's first data).
  - row_cnt[c] increments on each col_valid_i[c] while below num_rows and saturates at num_rows.
  - col_valid_i[c] with row_cnt[c]==num_rows sets err_o; the counter is unchanged and no bias_valid is driven.
  - Columns run independently; any skew is allowed.
  - When every counter equals num_rows, including counters reaching it this cycle, next state is DONE.
- DONE: lasts one cycle.
  - done_o=1 (registered: if the last valid is at cycle T, done_o is high at T+1).
  - Next state IDLE, so busy_o falls at T+2.
  - start_i is ignored in DONE.
- col_valid_i in IDLE, LOAD or DONE: sets err_o and drives no bias_valid_o. This includes the cycle of the final LOAD write.
- start_i in any state other than IDLE: ignored.
- Width rules:
  - Bias registers are stored and passed verbatim; no arithmetic on them.
  - Row counters are ROWS_W bits.

Test Plan:
- Load and run, N_COLS=8: start, num_rows=3, biases 10..17, then col c valid for 3 cycles skewed by c cycles → bias_valid_o[c] is high only on column c's first valid with bias_o[c]=10+c; done_o pulses one cycle after column 7's third valid; err_o=0.
- Backpressure: bias_wvalid_i toggling 1/0 during LOAD → exactly 8 words stored in order; state is RUN the cycle after the 8th accept; bias_wready_o=0 in RUN.
- Reuse: second start with reuse_i=1 and num_rows=2 → no LOAD (bias_wready_o never high); same biases reappear; done_o after 2 rows per column. Repeat after reset with reuse_i=1 → LOAD occurs.
- Errors: extra 4th valid on column 2 with num_rows=3 → err_o=1 and no bias_valid; valid during LOAD → err_o=1; start with num_rows=0 → stays IDLE and err_o=1; next good start clears err_o.
- Reset mid-RUN after 1 row: rst_ni low → all outputs 0 and state IDLE; then start with reuse_i=1 → goes to LOAD, and bias_o reads 0 until reloaded.
